// File: rtl/timer_arbiter_pkg.sv
// Shared definitions for the timer arbiter: FSM state encoding and default widths.
package timer_arbiter_pkg;

  localparam int unsigned DEF_NUM_REQ = 4;
  localparam int unsigned DEF_CNT_W   = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_RUN   = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/timer_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first set request at or after i_ptr+1, wrapping.
module timer_arbiter_rr_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned PTR_W   = 2
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [PTR_W-1:0]   i_ptr,
  output logic [NUM_REQ-1:0] o_gnt,
  output logic               o_valid
);

  int unsigned w_idx;
  logic        w_found;

  assign o_valid = |i_req;

  // Walk the requesters starting just past the last owner; the first hit wins.
  always_comb begin
    o_gnt   = '0;
    w_found = 1'b0;
    w_idx   = 0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      w_idx = 32'(i_ptr) + k;
      if (w_idx >= NUM_REQ) begin
        w_idx = w_idx - NUM_REQ;
      end
      if (!w_found && i_req[PTR_W'(w_idx)]) begin
        o_gnt[PTR_W'(w_idx)] = 1'b1;
        w_found              = 1'b1;
      end
    end
  end

endmodule

// File: rtl/timer_arbiter.sv
// Shares one external clk_counter among NUM_REQ requesters with round-robin grants.
// Define TIMER_ARB_ABORT_EN to let an owner abort its run by dropping req in CLEAR/RUN.
module timer_arbiter
  import timer_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ = DEF_NUM_REQ,
  parameter int unsigned CNT_W   = DEF_CNT_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*CNT_W-1:0] req_dur,
  output logic [NUM_REQ-1:0]       gnt,
  output logic [NUM_REQ-1:0]       done,
  output logic                     busy,
  output logic                     cnt_en,
  output logic                     cnt_clr,
  input  logic [CNT_W-1:0]         cnt_value
);

  localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  state_e             r_state;
  state_e             w_state_nxt;
  logic [NUM_REQ-1:0] r_gnt;
  logic [NUM_REQ-1:0] w_gnt_nxt;
  logic [NUM_REQ-1:0] r_done;
  logic               r_busy;
  logic               r_cnt_clr;
  logic [PTR_W-1:0]   r_ptr;
  logic [PTR_W-1:0]   w_ptr_nxt;
  logic [CNT_W-1:0]   r_dur_lat;
  logic [CNT_W-1:0]   w_dur_nxt;
  logic [NUM_REQ-1:0] w_arb_gnt;
  logic               w_arb_valid;
  logic               w_at_dur;
  logic               w_abort;

  timer_arbiter_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_rr_arbiter (
    .i_req   (req),
    .i_ptr   (r_ptr),
    .o_gnt   (w_arb_gnt),
    .o_valid (w_arb_valid)
  );

  assign w_at_dur = (cnt_value == r_dur_lat);

`ifdef TIMER_ARB_ABORT_EN
  assign w_abort = ~|(req & r_gnt);
`else
  assign w_abort = 1'b0;
`endif

  // Counter enable follows the live count so it stops exactly at the latched duration.
  assign cnt_en  = (r_state == ST_RUN) && !w_at_dur && !w_abort;
  assign gnt     = r_gnt;
  assign done    = r_done;
  assign busy    = r_busy;
  assign cnt_clr = r_cnt_clr;

  // Next-state, next-owner and duration latch.
  always_comb begin
    w_state_nxt = r_state;
    w_gnt_nxt   = r_gnt;
    w_ptr_nxt   = r_ptr;
    w_dur_nxt   = r_dur_lat;
    case (r_state)
      ST_IDLE: begin
        if (w_arb_valid) begin
          w_state_nxt = ST_CLEAR;
          w_gnt_nxt   = w_arb_gnt;
          for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (w_arb_gnt[i]) begin
              w_ptr_nxt = PTR_W'(i);
              w_dur_nxt = req_dur[i*CNT_W +: CNT_W];
            end
          end
        end
      end
      ST_CLEAR: begin
        if (w_abort) begin
          w_state_nxt = ST_IDLE;
          w_gnt_nxt   = '0;
        end else begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        if (w_abort) begin
          w_state_nxt = ST_IDLE;
          w_gnt_nxt   = '0;
        end else if (w_at_dur) begin
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
        w_gnt_nxt   = '0;
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_gnt_nxt   = '0;
      end
    endcase
  end

  // State and registered outputs, decoded from the next state so they align with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_gnt     <= '0;
      r_done    <= '0;
      r_busy    <= 1'b0;
      r_cnt_clr <= 1'b0;
      r_ptr     <= PTR_W'(NUM_REQ - 1);
      r_dur_lat <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_gnt     <= w_gnt_nxt;
      r_done    <= (w_state_nxt == ST_DONE) ? w_gnt_nxt : '0;
      r_busy    <= (w_state_nxt != ST_IDLE);
      r_cnt_clr <= (w_state_nxt == ST_CLEAR);
      r_ptr     <= w_ptr_nxt;
      r_dur_lat <= w_dur_nxt;
    end
  end

endmodule

// File: tb/tb_timer_arbiter.sv
// Directed self-checking bench for timer_arbiter driving a behavioural clk_counter.
module tb_timer_arbiter;

  localparam int unsigned NR = 4;
  localparam int unsigned CW = 32;

  logic              clk;
  logic              rst_n;
  logic [NR-1:0]     req;
  logic [NR*CW-1:0]  req_dur;
  logic [NR-1:0]     gnt;
  logic [NR-1:0]     done;
  logic              busy;
  logic              cnt_en;
  logic              cnt_clr;
  logic [CW-1:0]     cnt_value;

  int n_checks;
  int n_errors;

  timer_arbiter #(.NUM_REQ(NR), .CNT_W(CW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .req_dur   (req_dur),
    .gnt       (gnt),
    .done      (done),
    .busy      (busy),
    .cnt_en    (cnt_en),
    .cnt_clr   (cnt_clr),
    .cnt_value (cnt_value)
  );

  // Behavioural clk_counter: synchronous clear, count while enabled, no reset.
  always_ff @(posedge clk) begin
    if (cnt_clr)     cnt_value <= '0;
    else if (cnt_en) cnt_value <= cnt_value + 32'd1;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic set_req(input int idx, input logic [31:0] dur);
    req_dur[idx*CW +: CW] = dur;
    req[idx]              = 1'b1;
  endtask

  // Wait for a grant, then follow one full run of owner idx and check its timing.
  task automatic serve(input string tag, input int idx, input int dur, input bit drop,
                       output int wait_cyc);
    int en_n, clr_n, done_at, bad_gnt;
    logic [NR-1:0] exp_g;
    exp_g    = NR'(1) << idx;
    wait_cyc = 0;
    while (gnt == '0 && wait_cyc < 100) begin
      tick();
      wait_cyc++;
    end
    check({tag, "_owner"}, 32'(gnt), 32'(exp_g));
    en_n = 0; clr_n = 0; done_at = -1; bad_gnt = 0;
    for (int c = 0; c < dur + 20; c++) begin
      if (gnt != exp_g) bad_gnt++;
      if (cnt_en)  en_n++;
      if (cnt_clr) clr_n++;
      if (done != '0) begin
        done_at = c;
        check({tag, "_done_vec"}, 32'(done), 32'(exp_g));
        check({tag, "_cnt_hold"}, cnt_value, 32'(dur));
        if (drop) req[idx] = 1'b0;
        break;
      end
      tick();
    end
    check({tag, "_done_at"}, 32'(done_at), 32'(dur + 2));
    check({tag, "_en_cycles"}, 32'(en_n), 32'(dur));
    check({tag, "_clr_cycles"}, 32'(clr_n), 32'd1);
    check({tag, "_gnt_stable"}, 32'(bad_gnt), 32'd0);
    tick();
    check({tag, "_idle_gnt"}, 32'(gnt), 32'd0);
    check({tag, "_idle_busy"}, 32'(busy), 32'd0);
    check({tag, "_idle_done"}, 32'(done), 32'd0);
  endtask

  initial begin
    int w;
    int saw_done;
    n_checks = 0;
    n_errors = 0;
    req      = '0;
    req_dur  = '0;
    do_reset();

    // Reset values
    check("rst_gnt", 32'(gnt), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_cnt_en", 32'(cnt_en), 32'd0);
    check("rst_cnt_clr", 32'(cnt_clr), 32'd0);

    // 1. Single request, dur=5
    set_req(1, 32'd5);
    serve("t1", 1, 5, 1'b1, w);
    check("t1_wait", 32'(w), 32'd1);

    // 2. All four requesting from reset: grant order 0,1,2,3 with one idle cycle between
    req = '0;
    do_reset();
    for (int i = 0; i < 4; i++) set_req(i, 32'd2);
    for (int i = 0; i < 4; i++) begin
      serve($sformatf("t2_%0d", i), i, 2, 1'b1, w);
      check($sformatf("t2_%0d_wait", i), 32'(w), 32'd1);
    end

    // 3. Zero duration
    set_req(2, 32'd0);
    serve("t3", 2, 0, 1'b1, w);

    // 4. req[0] held forever with req[3] pending: grants alternate
    req = '0;
    do_reset();
    set_req(0, 32'd1);
    set_req(3, 32'd3);
    serve("t4_a", 0, 1, 1'b0, w);
    serve("t4_b", 3, 3, 1'b0, w);
    serve("t4_c", 0, 1, 1'b0, w);
    serve("t4_d", 3, 3, 1'b0, w);
    req = '0;
    tick();
    tick();

    // 5. Drop req[1] three cycles into RUN with dur=10
    set_req(1, 32'd10);
    w = 0;
    while (gnt == '0 && w < 100) begin tick(); w++; end
    check("t5_owner", 32'(gnt), 32'b0010);
    tick(); tick(); tick();
    req[1] = 1'b0;
`ifdef TIMER_ARB_ABORT_EN
    tick();
    check("t5_abort_gnt", 32'(gnt), 32'd0);
    check("t5_abort_busy", 32'(busy), 32'd0);
    check("t5_abort_en", 32'(cnt_en), 32'd0);
    saw_done = 0;
    for (int c = 0; c < 15; c++) begin
      if (done != '0) saw_done++;
      tick();
    end
    check("t5_no_done", 32'(saw_done), 32'd0);
`else
    saw_done = -1;
    for (int c = 3; c < 30; c++) begin
      if (done != '0) begin
        saw_done = c;
        check("t5_done_vec", 32'(done), 32'b0010);
        break;
      end
      tick();
    end
    check("t5_done_at", 32'(saw_done), 32'd12);
    tick();
    check("t5_idle_gnt", 32'(gnt), 32'd0);
`endif

    // 6. Async reset mid-run, then a fresh run restarts the counter from 0
    set_req(2, 32'd20);
    w = 0;
    while (gnt == '0 && w < 100) begin tick(); w++; end
    check("t6_owner", 32'(gnt), 32'b0100);
    repeat (5) tick();
    rst_n = 1'b0;
    #1;
    check("t6_rst_gnt", 32'(gnt), 32'd0);
    check("t6_rst_busy", 32'(busy), 32'd0);
    check("t6_rst_en", 32'(cnt_en), 32'd0);
    check("t6_rst_clr", 32'(cnt_clr), 32'd0);
    check("t6_rst_done", 32'(done), 32'd0);
    tick();
    tick();
    req_dur[2*CW +: CW] = 32'd3;
    rst_n = 1'b1;
    serve("t6_post", 2, 3, 1'b1, w);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", n_errors);
    $fatal(1);
  end

endmodule
